mult_128_arbiter: RTL and testbench

//  Shares one mult_128 (64x64->128, valid/ready streams) between two requesters (0: key/exp path, 1: cipher path).

---
 rtl/mult_128_arbiter.sv | 144 ++++++++++++++
 tb/tb_mult_128_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_128_arbiter.sv
// Round-robin arbiter sharing one 64x64->128 multiplier between two requesters.
// One multiplication in flight; the product is returned only to the requester that issued it.
module mult_128_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [WIDTH-1:0]   req0_a_tdata,
    input  logic [WIDTH-1:0]   req0_b_tdata,
    input  logic               req0_tvalid,
    output logic               req0_tready,
    output logic [2*WIDTH-1:0] rsp0_tdata,
    output logic               rsp0_tvalid,
    input  logic               rsp0_tready,

    input  logic [WIDTH-1:0]   req1_a_tdata,
    input  logic [WIDTH-1:0]   req1_b_tdata,
    input  logic               req1_tvalid,
    output logic               req1_tready,
    output logic [2*WIDTH-1:0] rsp1_tdata,
    output logic               rsp1_tvalid,
    input  logic               rsp1_tready,

    output logic [WIDTH-1:0]   mult_a_tdata,
    output logic [WIDTH-1:0]   mult_b_tdata,
    output logic               mult_a_tvalid,
    output logic               mult_b_tvalid,
    input  logic               mult_a_tready,
    input  logic               mult_b_tready,
    input  logic [2*WIDTH-1:0] mult_tdata,
    input  logic               mult_tvalid,
    output logic               mult_tready,

    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic               owner;
    logic               last;
    logic               a_done;
    logic               b_done;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] result;

    logic grant_valid;
    logic grant;
    logic accept;
    logic a_fire;
    logic b_fire;
    logic rsp_fire;

    // Contention goes to whichever requester did not finish the previous operation.
    always_comb begin
        grant_valid = req0_tvalid | req1_tvalid;
        grant       = 1'b0;
        if (req0_tvalid && req1_tvalid) begin
            grant = ~last;
        end else if (req1_tvalid) begin
            grant = 1'b1;
        end
    end

    assign accept      = rst && (state == IDLE) && grant_valid;
    assign req0_tready = accept && !grant;
    assign req1_tready = accept && grant;

    assign mult_a_tdata  = op_a;
    assign mult_b_tdata  = op_b;
    assign mult_a_tvalid = (state == ISSUE) && !a_done;
    assign mult_b_tvalid = (state == ISSUE) && !b_done;
    assign a_fire        = mult_a_tvalid && mult_a_tready;
    assign b_fire        = mult_b_tvalid && mult_b_tready;
    assign mult_tready   = (state == WAIT);

    assign rsp0_tdata  = result;
    assign rsp1_tdata  = result;
    assign rsp0_tvalid = (state == RESP) && !owner;
    assign rsp1_tvalid = (state == RESP) && owner;
    assign rsp_fire    = (state == RESP) && (owner ? rsp1_tready : rsp0_tready);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= grant ? req1_a_tdata : req0_a_tdata;
                        op_b  <= grant ? req1_b_tdata : req0_b_tdata;
                        owner <= grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The two operand channels may complete in either order or together.
                    if ((a_done || a_fire) && (b_done || b_fire)) begin
                        a_done <= 1'b0;
                        b_done <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        if (a_fire) a_done <= 1'b1;
                        if (b_fire) b_done <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mult_tvalid) begin
                        result <= mult_tdata;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_fire) begin
                        last     <= owner;
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_128_arbiter.sv
// Randomized self-checking bench for mult_128_arbiter with a behavioural multiplier
// stand-in and a rule-level model of grant order, products and operation count.
module tb_mult_128_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  req0_a, req0_b, req1_a, req1_b;
    logic         req0_tvalid, req1_tvalid, req0_tready, req1_tready;
    logic [127:0] rsp0_tdata, rsp1_tdata;
    logic         rsp0_tvalid, rsp1_tvalid, rsp0_tready, rsp1_tready;
    logic [63:0]  mult_a_tdata, mult_b_tdata;
    logic         mult_a_tvalid, mult_b_tvalid, mult_a_tready, mult_b_tready;
    logic [127:0] mult_tdata;
    logic         mult_tvalid, mult_tready;
    logic         busy;
    logic [15:0]  op_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: who won last and how many operations completed.
    bit          exp_last  = 1'b1;
    logic [15:0] exp_count = '0;

    // Multiplier stand-in: per-channel ready delay and output latency are bench-controlled.
    int          a_delay_cfg = 0;
    int          b_delay_cfg = 0;
    int          lat_cfg     = 1;
    logic        have_a, have_b, out_valid;
    logic [63:0] ma, mb;
    logic [127:0] out_data;
    int          a_stall, b_stall, lat_cnt;
    int          prod_count = 0;

    mult_128_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_a_tdata  (req0_a),
        .req0_b_tdata  (req0_b),
        .req0_tvalid   (req0_tvalid),
        .req0_tready   (req0_tready),
        .rsp0_tdata    (rsp0_tdata),
        .rsp0_tvalid   (rsp0_tvalid),
        .rsp0_tready   (rsp0_tready),
        .req1_a_tdata  (req1_a),
        .req1_b_tdata  (req1_b),
        .req1_tvalid   (req1_tvalid),
        .req1_tready   (req1_tready),
        .rsp1_tdata    (rsp1_tdata),
        .rsp1_tvalid   (rsp1_tvalid),
        .rsp1_tready   (rsp1_tready),
        .mult_a_tdata  (mult_a_tdata),
        .mult_b_tdata  (mult_b_tdata),
        .mult_a_tvalid (mult_a_tvalid),
        .mult_b_tvalid (mult_b_tvalid),
        .mult_a_tready (mult_a_tready),
        .mult_b_tready (mult_b_tready),
        .mult_tdata    (mult_tdata),
        .mult_tvalid   (mult_tvalid),
        .mult_tready   (mult_tready),
        .busy          (busy),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    assign mult_a_tready = !have_a && (a_stall >= a_delay_cfg);
    assign mult_b_tready = !have_b && (b_stall >= b_delay_cfg);
    assign mult_tvalid   = out_valid;
    assign mult_tdata    = out_data;

    always @(posedge clk) begin
        if (!rst) begin
            have_a    <= 1'b0;
            have_b    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ma        <= '0;
            mb        <= '0;
            a_stall   <= 0;
            b_stall   <= 0;
            lat_cnt   <= 0;
        end else begin
            if (mult_a_tvalid && mult_a_tready) begin
                have_a <= 1'b1; ma <= mult_a_tdata; a_stall <= 0;
            end else if (mult_a_tvalid && !have_a) begin
                a_stall <= a_stall + 1;
            end
            if (mult_b_tvalid && mult_b_tready) begin
                have_b <= 1'b1; mb <= mult_b_tdata; b_stall <= 0;
            end else if (mult_b_tvalid && !have_b) begin
                b_stall <= b_stall + 1;
            end
            if (have_a && have_b && !out_valid) begin
                if (lat_cnt >= lat_cfg) begin
                    out_valid <= 1'b1;
                    out_data  <= {64'b0, ma} * {64'b0, mb};
                    have_a    <= 1'b0;
                    have_b    <= 1'b0;
                    lat_cnt   <= 0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
            if (out_valid && mult_tready) begin
                out_valid  <= 1'b0;
                prod_count <= prod_count + 1;
            end
        end
    end

    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) return (exp_last == 1'b0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b);
        return {64'b0, a} * {64'b0, b};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_last  = 1'b1;
        exp_count = '0;
    endtask

    task automatic send(input int n, input logic [63:0] a, input logic [63:0] b, output bit ok);
        if (n == 0) begin req0_a = a; req0_b = b; req0_tvalid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_tvalid = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((n == 0) ? req0_tready : req1_tready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (n == 0) req0_tvalid = 1'b0; else req1_tvalid = 1'b0;
    endtask

    task automatic wait_rsp(input bit consume, output int who, output logic [127:0] data, output bit ok);
        ok = 1'b0; who = -1; data = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp0_tvalid || rsp1_tvalid) begin
                ok   = 1'b1;
                who  = (rsp0_tvalid && rsp1_tvalid) ? 2 : (rsp1_tvalid ? 1 : 0);
                data = rsp0_tdata;
                break;
            end
        end
        if (ok && consume) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_a = 64'd3; req0_b = 64'd4; req1_a = 64'd5; req1_b = 64'd6;
        req0_tvalid = 1'b1; req1_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req0_tready, req1_tready} !== 2'b00) begin
            tests_failed++; $display("[TB] FAIL reset_req_tready: got %b expected 00", {req0_tready, req1_tready});
        end
        tests_run++;
        if ({mult_a_tvalid, mult_b_tvalid, mult_tready} !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_mult_hs: got %b expected 000", {mult_a_tvalid, mult_b_tvalid, mult_tready});
        end
        tests_run++;
        if ({rsp0_tvalid, rsp1_tvalid, busy} !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_rsp_busy: got %b expected 000", {rsp0_tvalid, rsp1_tvalid, busy});
        end
        tests_run++;
        if (op_count !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count);
        end
        req0_tvalid = 1'b0; req1_tvalid = 1'b0;
        rst = 1'b1;
        exp_last = 1'b1; exp_count = '0;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        bit ok; int who; logic [127:0] data;
        rsp0_tready = 1'b1; rsp1_tready = 1'b1;
        send(0, 64'd123123124443096802, 64'd314141255378583275, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL single_accept: got timeout expected accept"); end
        wait_rsp(1'b1, who, data, ok);
        tests_run++;
        if (!ok || who !== pick(1'b1, 1'b0)) begin
            tests_failed++; $display("[TB] FAIL single_owner: got %0d expected 0", who);
        end
        tests_run++;
        if (data !== 128'h772F9A9308D2F4ECEC030C49E6D76) begin
            tests_failed++; $display("[TB] FAIL single_product: got %h expected %h", data, 128'h772F9A9308D2F4ECEC030C49E6D76);
        end
        exp_last = 1'b0; exp_count++;
        tests_run++;
        if (op_count !== exp_count || busy !== 1'b0 || rsp0_tvalid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL single_done: got count %0d busy %b expected count %0d busy 0", op_count, busy, exp_count);
        end
    endtask

    task automatic test_contention();
        bit ok; int who, w; logic [127:0] data;
        do_reset();
        rsp0_tready = 1'b1; rsp1_tready = 1'b1;
        req0_a = 64'd3; req0_b = 64'd5; req1_a = 64'd7; req1_b = 64'd9;
        req0_tvalid = 1'b1; req1_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = pick(1'b1, 1'b1);
            wait_rsp(1'b1, who, data, ok);
            tests_run++;
            if (!ok || who !== w) begin
                tests_failed++; $display("[TB] FAIL contention_grant%0d: got %0d expected %0d", k, who, w);
            end
            tests_run++;
            if (data !== ((w == 0) ? 128'd15 : 128'd63)) begin
                tests_failed++; $display("[TB] FAIL contention_data%0d: got %0d expected %0d", k, data, (w == 0) ? 15 : 63);
            end
            exp_last = w[0]; exp_count++;
        end
        req0_tvalid = 1'b0; req1_tvalid = 1'b0;
        tests_run++;
        if (op_count !== exp_count) begin
            tests_failed++; $display("[TB] FAIL contention_count: got %0d expected %0d", op_count, exp_count);
        end
    endtask

    task automatic test_back_pressure();
        bit ok; int who, a_cyc, b_cyc, p0; logic [127:0] data;
        logic [63:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        a_delay_cfg = 2; b_delay_cfg = 0; lat_cfg = 1;
        rsp0_tready = 1'b0; rsp1_tready = 1'b0;
        p0 = prod_count; a_cyc = 0; b_cyc = 0;
        send(0, a, b, ok);
        for (int i = 0; i < 8; i++) begin
            if (mult_a_tvalid) begin
                a_cyc++; tests_run++;
                if (mult_a_tdata !== a) begin tests_failed++; $display("[TB] FAIL bp_a_stable: got %h expected %h", mult_a_tdata, a); end
            end
            if (mult_b_tvalid) begin
                b_cyc++; tests_run++;
                if (mult_b_tdata !== b) begin tests_failed++; $display("[TB] FAIL bp_b_stable: got %h expected %h", mult_b_tdata, b); end
            end
            @(negedge clk);
        end
        tests_run++;
        if (a_cyc !== 3 || b_cyc !== 1) begin
            tests_failed++; $display("[TB] FAIL bp_issue_cycles: got a=%0d b=%0d expected a=3 b=1", a_cyc, b_cyc);
        end
        wait_rsp(1'b0, who, data, ok);
        tests_run++;
        if (!ok || who !== 0 || data !== prod(a, b)) begin
            tests_failed++; $display("[TB] FAIL bp_rsp: got who %0d data %h expected who 0 data %h", who, data, prod(a, b));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp0_tvalid !== 1'b1 || rsp0_tdata !== prod(a, b) || op_count !== exp_count) begin
                tests_failed++; $display("[TB] FAIL bp_hold%0d: got valid %b count %0d expected valid 1 count %0d", i, rsp0_tvalid, op_count, exp_count);
            end
        end
        rsp0_tready = 1'b1;
        @(negedge clk);
        exp_last = 1'b0; exp_count++;
        tests_run++;
        if (op_count !== exp_count || rsp0_tvalid !== 1'b0 || (prod_count - p0) !== 1) begin
            tests_failed++; $display("[TB] FAIL bp_release: got count %0d products %0d expected count %0d products 1", op_count, prod_count - p0, exp_count);
        end
        a_delay_cfg = 0; rsp1_tready = 1'b1;
    endtask

    task automatic test_edges();
        bit ok; int who; logic [127:0] data; logic [63:0] r;
        rsp0_tready = 1'b1; rsp1_tready = 1'b1;
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        wait_rsp(1'b1, who, data, ok);
        tests_run++;
        if (!ok || who !== 1 || data !== 128'hFFFFFFFFFFFFFFFE0000000000000001) begin
            tests_failed++; $display("[TB] FAIL edge_max: got who %0d data %h expected who 1 data %h", who, data, 128'hFFFFFFFFFFFFFFFE0000000000000001);
        end
        exp_last = 1'b1; exp_count++;
        r = {$urandom, $urandom} | 64'h1;
        send(0, 64'd0, r, ok);
        wait_rsp(1'b1, who, data, ok);
        tests_run++;
        if (!ok || who !== 0 || data !== 128'd0) begin
            tests_failed++; $display("[TB] FAIL edge_zero: got who %0d data %h expected who 0 data 0", who, data);
        end
        exp_last = 1'b0; exp_count++;
        tests_run++;
        if (op_count !== exp_count) begin
            tests_failed++; $display("[TB] FAIL edge_count: got %0d expected %0d", op_count, exp_count);
        end
    endtask

    task automatic test_random();
        bit ok, v0, v1; int who, w, hold; logic [127:0] data, exp;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0:       begin v0 = 1'b1; v1 = 1'b0; end
                1:       begin v0 = 1'b0; v1 = 1'b1; end
                default: begin v0 = 1'b1; v1 = 1'b1; end
            endcase
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            a_delay_cfg = $urandom_range(0, 3); b_delay_cfg = $urandom_range(0, 3);
            lat_cfg = $urandom_range(0, 4);
            hold = $urandom_range(0, 3);
            rsp0_tready = (hold == 0); rsp1_tready = (hold == 0);
            w   = pick(v0, v1);
            exp = (w == 0) ? prod(req0_a, req0_b) : prod(req1_a, req1_b);
            req0_tvalid = v0; req1_tvalid = v1;
            wait_rsp(1'b0, who, data, ok);
            req0_tvalid = 1'b0; req1_tvalid = 1'b0;
            repeat (hold) @(negedge clk);
            rsp0_tready = 1'b1; rsp1_tready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (!ok || who !== w || data !== exp) begin
                tests_failed++; $display("[TB] FAIL random%0d: got who %0d data %h expected who %0d data %h", k, who, data, w, exp);
            end
            exp_last = w[0]; exp_count++;
            tests_run++;
            if (op_count !== exp_count) begin
                tests_failed++; $display("[TB] FAIL random_count%0d: got %0d expected %0d", k, op_count, exp_count);
            end
        end
        a_delay_cfg = 0; b_delay_cfg = 0; lat_cfg = 1;
    endtask

    task automatic test_reset_mid_op();
        bit ok, in_wait; int who; logic [127:0] data; logic [63:0] a, b;
        do_reset();
        rsp0_tready = 1'b1; rsp1_tready = 1'b1;
        lat_cfg = 30;
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, ok);
        in_wait = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mult_tready) begin in_wait = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!in_wait) begin tests_failed++; $display("[TB] FAIL midreset_reach_wait: got timeout expected WAIT"); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || rsp0_tvalid !== 1'b0 || rsp1_tvalid !== 1'b0 || mult_tready !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midreset_idle: got busy %b rsp %b%b expected all 0", busy, rsp0_tvalid, rsp1_tvalid);
        end
        tests_run++;
        if (op_count !== exp_count) begin
            tests_failed++; $display("[TB] FAIL midreset_count: got %0d expected %0d", op_count, exp_count);
        end
        rst = 1'b1; exp_last = 1'b1; lat_cfg = 1;
        @(negedge clk);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send(1, a, b, ok);
        wait_rsp(1'b1, who, data, ok);
        exp_count++;
        tests_run++;
        if (!ok || who !== 1 || data !== prod(a, b) || op_count !== exp_count) begin
            tests_failed++; $display("[TB] FAIL midreset_next: got who %0d data %h count %0d expected who 1 data %h count %0d", who, data, op_count, prod(a, b), exp_count);
        end
    endtask

    initial begin
        rst = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_tvalid = 1'b0; req1_tvalid = 1'b0;
        rsp0_tready = 1'b0; rsp1_tready = 1'b0;
        test_reset();
        test_single_op();
        test_contention();
        test_back_pressure();
        test_edges();
        test_random();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
